// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter: FSM encodings, default widths
// and the fetch starvation limit.
`timescale 1ns/1ps
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned STARVE_CNT_W   = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GNT_IF = 2'd1;
  localparam logic [1:0] ST_GNT_D  = 2'd2;

  // True once data has overtaken a waiting fetch the maximum number of times.
  function automatic logic fetch_forced(input logic [STARVE_CNT_W-1:0] cnt,
                                        input int unsigned           limit);
    return cnt >= STARVE_CNT_W'(limit);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one req/ack memory port between instruction fetch and data accesses.
// Data wins ties, but a waiting fetch is granted after STARVE_MAX data grants.
`timescale 1ns/1ps
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  logic [1:0]              state, state_nxt;
  logic [STARVE_CNT_W-1:0] starve_cnt, starve_cnt_nxt;
  logic                    mem_req_nxt, mem_we_nxt, mem_byte_nxt;
  logic [ADDR_W-1:0]       mem_addr_nxt;
  logic [DATA_W-1:0]       mem_wdata_nxt;
  logic                    if_done_nxt, d_done_nxt, busy_nxt;
  logic [DATA_W-1:0]       if_rdata_nxt, d_rdata_nxt;
  logic                    d_req;

  assign d_req = d_read | d_write;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_byte   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_byte   <= mem_byte_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      if_done    <= if_done_nxt;
      d_done     <= d_done_nxt;
      if_rdata   <= if_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      busy       <= busy_nxt;
    end
  end

  // Arbitration, command launch and completion
  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    mem_req_nxt    = mem_req;
    mem_we_nxt     = mem_we;
    mem_byte_nxt   = mem_byte;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    if_done_nxt    = 1'b0;
    d_done_nxt     = 1'b0;
    if_rdata_nxt   = if_rdata;
    d_rdata_nxt    = d_rdata;

    case (state)
      ST_IDLE: begin
        if (d_req && !(if_req && fetch_forced(starve_cnt, STARVE_MAX))) begin
          state_nxt      = ST_GNT_D;
          starve_cnt_nxt = if_req ? starve_cnt + STARVE_CNT_W'(1) : '0;
          mem_req_nxt    = 1'b1;
          mem_we_nxt     = d_write;
          mem_byte_nxt   = d_byte;
          mem_addr_nxt   = d_addr;
          mem_wdata_nxt  = d_wdata;
        end else if (if_req) begin
          state_nxt      = ST_GNT_IF;
          starve_cnt_nxt = '0;
          mem_req_nxt    = 1'b1;
          mem_we_nxt     = 1'b0;
          mem_byte_nxt   = 1'b0;
          mem_addr_nxt   = if_addr;
          mem_wdata_nxt  = '0;
        end else begin
          starve_cnt_nxt = '0;
        end
      end
      ST_GNT_IF: begin
        if (mem_ack) begin
          state_nxt    = ST_IDLE;
          mem_req_nxt  = 1'b0;
          if_rdata_nxt = mem_rdata;
          if_done_nxt  = 1'b1;
        end
      end
      ST_GNT_D: begin
        if (mem_ack) begin
          state_nxt   = ST_IDLE;
          mem_req_nxt = 1'b0;
          d_rdata_nxt = mem_rdata;
          d_done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        mem_req_nxt = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester drivers, a behavioural
// memory, and a monitor that checks every grant and every done pulse.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SMAX = 4;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          d_read, d_write, d_byte;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we, mem_byte;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          busy;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_read(d_read), .d_write(d_write), .d_byte(d_byte), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          who;      // 1 = data, 0 = fetch
    logic          store;
    logic [DW-1:0] rdata;
    int            ack_cyc;
  } resp_t;

  typedef struct {
    logic [AW-1:0] addr;
    int            cyc;
  } grant_t;

  resp_t  sb_q[$];
  grant_t glog[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_if_done = 0;
  int n_d_done = 0;
  int last_d_done_cyc = -1;

  // Memory behaviour knobs
  int            lat_min = 0;
  int            lat_max = 0;
  bit            fixed_rd_en = 1'b0;
  logic [DW-1:0] fixed_rd = '0;
  bit            mem_auto = 1'b1;
  bit            ack_pulse_req = 1'b0;

  // Requests as seen by the DUT at the latest rising edge
  logic          s_if_req, s_d_read, s_d_write, s_d_byte;
  logic [AW-1:0] s_if_addr, s_d_addr;
  logic [DW-1:0] s_d_wdata;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    s_if_req  <= if_req;
    s_if_addr <= if_addr;
    s_d_read  <= d_read;
    s_d_write <= d_write;
    s_d_byte  <= d_byte;
    s_d_addr  <= d_addr;
    s_d_wdata <= d_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor state and expected command of the access in flight
  logic          mem_req_prev;
  int            overtakes;
  bit            armed;
  int            lat_left;
  logic          g_who, g_we, g_byte, g_store;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata, rd;
  resp_t         r;
  logic          s_d_req, exp_d;

  // Monitor + behavioural memory, evaluated on the falling edge
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    mem_req_prev = 1'b0;
    overtakes = 0;
    armed = 1'b0;
    lat_left = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb_q.delete();
        mem_req_prev = 1'b0;
        overtakes = 0;
        armed = 1'b0;
        lat_left = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
      end else begin
        if (if_done || d_done) begin
          if (if_done) n_if_done++;
          if (d_done) begin
            n_d_done++;
            last_d_done_cyc = cyc;
          end
          chk("done_exclusive", 64'(if_done & d_done), 64'd0);
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: if_done=%0b d_done=%0b with nothing acked (t=%0t)",
                     if_done, d_done, $time);
          end else begin
            r = sb_q.pop_front();
            chk("done_who", 64'(d_done), 64'(r.who));
            chk("done_after_ack", 64'(cyc - r.ack_cyc), 64'd1);
            if (!r.store) chk("rdata", 64'(r.who ? d_rdata : if_rdata), 64'(r.rdata));
          end
        end
        if (sb_q.size() > 0 && sb_q[0].ack_cyc + 1 < cyc) begin
          n_cmp++;
          n_fail++;
          $display("FAIL missing_done: ack in cycle %0d produced no done pulse", sb_q[0].ack_cyc);
          void'(sb_q.pop_front());
        end

        if (mem_req && !mem_req_prev) begin
          // Data wins unless it has already overtaken a waiting fetch SMAX times
          s_d_req = s_d_read | s_d_write;
          if (s_d_req && !(s_if_req && overtakes >= int'(SMAX))) begin
            exp_d = 1'b1;
            overtakes = s_if_req ? overtakes + 1 : 0;
          end else begin
            exp_d = 1'b0;
            overtakes = 0;
            if (!s_if_req) begin
              n_cmp++;
              n_fail++;
              $display("FAIL spurious_grant: mem_req rose with no request pending (t=%0t)", $time);
            end
          end
          g_who   = exp_d;
          g_we    = exp_d ? s_d_write : 1'b0;
          g_byte  = exp_d ? s_d_byte : 1'b0;
          g_addr  = exp_d ? s_d_addr : s_if_addr;
          g_wdata = exp_d ? s_d_wdata : '0;
          g_store = exp_d & s_d_write;
          chk("grant_we", 64'(mem_we), 64'(g_we));
          chk("grant_byte", 64'(mem_byte), 64'(g_byte));
          chk("grant_addr", 64'(mem_addr), 64'(g_addr));
          chk("grant_wdata", 64'(mem_wdata), 64'(g_wdata));
          chk("grant_busy", 64'(busy), 64'd1);
          glog.push_back('{addr: mem_addr, cyc: cyc});
        end else if (mem_req) begin
          chk("hold_we", 64'(mem_we), 64'(g_we));
          chk("hold_byte", 64'(mem_byte), 64'(g_byte));
          chk("hold_addr", 64'(mem_addr), 64'(g_addr));
          chk("hold_wdata", 64'(mem_wdata), 64'(g_wdata));
        end
        mem_req_prev = mem_req;

        if (mem_ack) begin
          mem_ack = 1'b0;
        end else if (mem_auto && mem_req) begin
          if (!armed) begin
            armed = 1'b1;
            lat_left = $urandom_range(lat_max, lat_min);
          end
          if (lat_left == 0) begin
            armed = 1'b0;
            rd = fixed_rd_en ? fixed_rd : DW'($urandom);
            mem_ack = 1'b1;
            mem_rdata = rd;
            sb_q.push_back('{who: g_who, store: g_store, rdata: rd, ack_cyc: cyc});
          end else begin
            lat_left--;
          end
        end else if (ack_pulse_req) begin
          mem_ack = 1'b1;
          mem_rdata = 32'h5A5A_5A5A;
          ack_pulse_req = 1'b0;
        end
      end
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the edge raising done
  task automatic wait_done(input bit is_d, output int done_cyc);
    bit seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (is_d ? d_done : if_done) seen = 1'b1;
    end
    done_cyc = cyc;
    chk(is_d ? "d_done_timeout" : "if_done_timeout", 64'(seen), 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_fetch(input int n, input logic [AW-1:0] base, input bit rand_addr,
                           input int gap_max, input bit chk_lat);
    int t_set, t_done, gap;
    for (int i = 0; i < n; i++) begin
      if_addr = rand_addr ? (AW'($urandom_range(0, 1023)) << 2) : base + AW'(4 * i);
      if_req  = 1'b1;
      t_set   = cyc;
      wait_done(1'b0, t_done);
      if (chk_lat) chk("if_latency", 64'(t_done - t_set), 64'd2);
      gap = $urandom_range(gap_max, 0);
      if (i == n - 1 || gap > 0) begin
        if_req = 1'b0;
        idle_cycles(gap);
      end
    end
  endtask

  task automatic run_data(input int n, input logic [AW-1:0] base, input bit rand_op,
                          input int gap_max);
    int t_done, gap, op;
    for (int i = 0; i < n; i++) begin
      op      = rand_op ? $urandom_range(0, 9) : 0;
      d_read  = (op <= 4) || (op == 9);
      d_write = (op >= 5);
      d_byte  = rand_op ? 1'($urandom_range(0, 1)) : 1'b0;
      d_addr  = rand_op ? base + AW'($urandom_range(0, 4095)) : base + AW'(4 * i);
      d_wdata = DW'($urandom);
      wait_done(1'b1, t_done);
      gap = $urandom_range(gap_max, 0);
      if (i == n - 1 || gap > 0) begin
        d_read  = 1'b0;
        d_write = 1'b0;
        idle_cycles(gap);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s, f0, d0, tdc;
    bit hit;
    reset = 1'b1;
    if_req = 1'b0;  if_addr = '0;
    d_read = 1'b0;  d_write = 1'b0; d_byte = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_if_done", 64'(if_done), 64'd0);
    chk("rst_d_done", 64'(d_done), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;

    // Fetch only, memory acks two cycles after mem_req rises
    lat_min = 2; lat_max = 2; fixed_rd_en = 1'b1; fixed_rd = 32'hDEAD_BEEF;
    s = glog.size(); f0 = n_if_done;
    run_fetch(1, 32'h100, 1'b0, 0, 1'b0);
    chk("t1_if_rdata", 64'(if_rdata), 64'hDEAD_BEEF);
    chk("t1_busy", 64'(busy), 64'd0);
    idle_cycles(2);
    chk("t1_if_done_cnt", 64'(n_if_done - f0), 64'd1);
    chk("t1_addr", 64'(glog[s].addr), 64'h100);
    fixed_rd_en = 1'b0;

    // Byte store
    lat_min = 1; lat_max = 3;
    s = glog.size(); f0 = n_if_done; d0 = n_d_done;
    d_write = 1'b1; d_byte = 1'b1; d_addr = 32'h204; d_wdata = 32'h0000_00AB;
    wait_done(1'b1, tdc);
    d_write = 1'b0; d_byte = 1'b0;
    idle_cycles(2);
    chk("t2_d_done_cnt", 64'(n_d_done - d0), 64'd1);
    chk("t2_if_done_cnt", 64'(n_if_done - f0), 64'd0);
    chk("t2_addr", 64'(glog[s].addr), 64'h204);

    // Zero-wait back-to-back fetches
    lat_min = 0; lat_max = 0;
    s = glog.size(); f0 = n_if_done;
    run_fetch(3, 32'h0, 1'b0, 0, 1'b1);
    idle_cycles(2);
    chk("t6_if_done_cnt", 64'(n_if_done - f0), 64'd3);
    for (int i = 0; i < 3; i++) chk("t6_addr_seq", 64'(glog[s + i].addr), 64'(4 * i));

    // Simultaneous requests with the starvation counter at zero
    lat_min = 0; lat_max = 2;
    s = glog.size();
    fork
      begin
        d_read = 1'b1; d_addr = 32'h8100;
        wait_done(1'b1, tdc);
        d_read = 1'b0;
      end
      begin
        if_req = 1'b1; if_addr = 32'h40;
        wait_done(1'b0, tdc);
        if_req = 1'b0;
      end
    join
    idle_cycles(2);
    chk("t4_first_data", 64'(glog[s].addr), 64'h8100);
    chk("t4_then_fetch", 64'(glog[s + 1].addr), 64'h40);
    chk("t4_fetch_after_d_done", 64'(glog[s + 1].cyc), 64'(last_d_done_cyc + 1));

    // Starvation bound with both requesters held high, zero-wait memory
    lat_min = 0; lat_max = 0;
    s = glog.size();
    fork
      run_fetch(2, 32'h100, 1'b0, 0, 1'b0);
      run_data(9, 32'h8000, 1'b0, 0);
    join
    idle_cycles(2);
    for (int i = 0; i < 10; i++)
      chk("t3_grant_is_fetch", 64'(glog[s + i].addr < 32'h8000),
          64'((i % (SMAX + 1)) == SMAX));

    // Randomised traffic against the reference model
    lat_min = 0; lat_max = 3;
    fork
      run_fetch(25, '0, 1'b1, 3, 1'b0);
      run_data(25, 32'h8000, 1'b1, 3);
    join
    idle_cycles(4);
    chk("rand_drained", 64'(sb_q.size()), 64'd0);
    chk("rand_busy", 64'(busy), 64'd0);

    // Reset in the middle of a data access
    mem_auto = 1'b0;
    f0 = n_if_done; d0 = n_d_done;
    d_read = 1'b1; d_addr = 32'h8200;
    hit = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin
      @(posedge clk);
      #1;
      hit = mem_req;
    end
    chk("t5_setup_busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_mem_req", 64'(mem_req), 64'd0);
    chk("t5_mem_we", 64'(mem_we), 64'd0);
    chk("t5_mem_byte", 64'(mem_byte), 64'd0);
    chk("t5_mem_addr", 64'(mem_addr), 64'd0);
    chk("t5_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("t5_if_rdata", 64'(if_rdata), 64'd0);
    chk("t5_d_rdata", 64'(d_rdata), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    d_read = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    ack_pulse_req = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("t5_stay_idle", 64'({busy, mem_req, if_done, d_done}), 64'd0);
    end
    chk("t5_no_d_done", 64'(n_d_done - d0), 64'd0);
    chk("t5_no_if_done", 64'(n_if_done - f0), 64'd0);
    mem_auto = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory/MMU port between the instruction-fetch requester and the data requester.
- Fetch is read-only, word-sized. Data carries read_mmu/write_mmu/byte_select_mmu from the decoder via the pipeline.
- Serialises accesses with a 3-state FSM over a req/ack memory handshake that has variable latency.
- Data has priority, with a bounded-starvation guarantee for fetch. Sits between the pipeline front/back ends and the memory.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_MAX, 4, maximum consecutive data grants while fetch is waiting; the next grant is forced to fetch. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held high until if_done
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_done  out  1  one-cycle pulse; if_rdata is valid in the same cycle
- if_rdata  out  DATA_W  fetched word
- d_read  in  1  data load request (read_mmu)
- d_write  in  1  data store request (write_mmu)
- d_byte  in  1  byte access (byte_select_mmu)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_done  out  1  one-cycle completion pulse
- d_rdata  out  DATA_W  load data; valid while d_done is high
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  1 = write
- mem_byte  out  1  byte access
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid while mem_ack is high
- mem_ack  in  1  memory completion; one-cycle pulse
- busy  out  1  high when the FSM is not in IDLE

Behaviour:
- Reset, asynchronous, acts immediately:
  - FSM goes to IDLE; the starvation counter clears to 0.
  - All outputs go to 0, including rdata registers.
  - Reset asserted mid-transaction aborts the transaction: no done pulse is produced, and any mem_ack arriving after reset is released is ignored in IDLE.
- Data request d_req = d_read | d_write. d_read and d_write high together is illegal; in that case the write takes effect (mem_we = 1).
- States:
  - IDLE: evaluate requests each cycle.
  - GNT_IF: fetch access outstanding.
  - GNT_D: data access outstanding.
- IDLE arbitration, registered; the grant takes effect on the next edge:
  - d_req only -> GNT_D.
  - if_req only -> GNT_IF.
  - Both pending and starve_cnt < STARVE_MAX -> GNT_D, and starve_cnt increments.
  - Both pending and starve_cnt == STARVE_MAX -> GNT_IF.
  - Neither pending -> stay in IDLE.
  - starve_cnt clears whenever GNT_IF is entered, and whenever IDLE is seen with if_req low.
- On entering a GNT state, register the memory command:
  - mem_req = 1.
  - mem_addr, mem_we, mem_byte, mem_wdata come from the granted requester.
  - Fetch forces mem_we = 0, mem_byte = 0, mem_wdata = 0.
  - These outputs are held constant until mem_ack.
- In a GNT state with mem_ack = 1:
  - Capture mem_rdata into if_rdata or d_rdata. d_rdata is captured for stores too; its value on a store is don't-care.
  - Pulse the matching done signal for exactly one cycle, in the cycle after mem_ack.
  - Drop mem_req and return to IDLE.
- Latency: request seen in IDLE at cycle t -> mem_req high at t+1 -> done pulse one cycle after mem_ack. Minimum is 3 cycles with a zero-wait memory (ack at t+1).
- Requesters deassert req in the cycle done is seen. IDLE re-samples requests in that cycle, so a back-to-back request from the same requester is granted on the following edge.
- Requester inputs are ignored while in GNT states. A mem_ack while in IDLE is ignored.
- if_rdata and d_rdata hold their value until the next capture.
- No combinational path from any input to any output.

Decomposition:
- Shared package/header (CONSTANTS.vh): the FSM state encodings ST_IDLE=2'd0, ST_GNT_IF=2'd1, ST_GNT_D=2'd2. Default STARVE_MAX is set here.
- Single module; no sub-module is required.
- The starvation counter is a 4-bit register inside the module.

Test Plan:
- Fetch only:
  - Stimulus: if_req=1, if_addr=0x100, memory acks 2 cycles after mem_req rises with mem_rdata=0xDEADBEEF.
  - Required: mem_req high with mem_we=0 and mem_addr=0x100; if_done pulses once with if_rdata=0xDEADBEEF; busy returns to 0.
- Byte store:
  - Stimulus: d_write=1, d_byte=1, d_addr=0x204, d_wdata=0x000000AB.
  - Required: mem_we=1, mem_byte=1, mem_addr=0x204, mem_wdata=0xAB held until ack; d_done pulses once; if_done stays 0.
- Starvation, with STARVE_MAX=4:
  - Stimulus: if_req and d_read held high continuously, zero-wait memory.
  - Required: grant order D,D,D,D,IF,D,D,D,D,IF. No fetch wait exceeds 4 data grants.
- Simultaneous requests with counter 0:
  - Stimulus: if_req and d_read rise in the same cycle.
  - Required: data is granted first; fetch is granted in the IDLE cycle after d_done.
- Reset mid-access:
  - Stimulus: assert reset while in GNT_D before mem_ack; pulse mem_ack after reset is released.
  - Required: all outputs are 0 immediately; no d_done or if_done pulse; FSM stays in IDLE.
- Zero-wait back-to-back:
  - Stimulus: mem_ack one cycle after each mem_req; 3 consecutive fetches at 0x0, 0x4, 0x8.
  - Required: each completes in 3 cycles; if_done fires once per access; mem_addr sequence is 0x0, 0x4, 0x8.
